// File: rtl/branch_predict_ctrl.sv
// Branch predictor and resolution controller: 2-bit counter table read in IF,
// trained in EX, with mispredict redirect, flush sequencing and perf counters.
module branch_predict_ctrl #(
    parameter int         IDX_BITS     = 6,
    parameter int         FLUSH_CYCLES = 2,
    parameter logic [1:0] CNT_INIT     = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        branch_sel,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [15:0] branch_count,
    output logic [15:0] mispredict_count
);

    localparam int DEPTH = 1 << IDX_BITS;
    localparam int FW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [FW-1:0]   r_flushCnt;
    logic [FW-1:0]   w_nextFlushCnt;
    logic            w_nextRedirValid;
    logic [31:0]     w_nextRedirPc;
    logic [1:0]      r_table [DEPTH];

    logic [IDX_BITS-1:0] w_ifIdx;
    logic [IDX_BITS-1:0] w_exIdx;
    logic                w_res;
    logic                w_mis;

    assign w_ifIdx = if_pc[IDX_BITS+1:2];
    assign w_exIdx = ex_pc[IDX_BITS+1:2];

    // Table is read before the edge, so a same-index update is seen next cycle.
    assign pred_taken = if_valid & r_table[w_ifIdx][1];

    assign w_res = ex_valid & ex_is_branch & (r_state == IDLE);
    assign w_mis = w_res & (branch_sel != ex_pred_taken);
    assign flush = (r_state == FLUSH);

    always_comb begin
        w_nextState      = r_state;
        w_nextFlushCnt   = r_flushCnt;
        w_nextRedirValid = 1'b0;
        w_nextRedirPc    = redirect_pc;
        case (r_state)
            IDLE: begin
                if (w_mis) begin
                    w_nextState      = FLUSH;
                    w_nextFlushCnt   = FW'(FLUSH_CYCLES - 1);
                    w_nextRedirValid = 1'b1;
                    w_nextRedirPc    = branch_sel ? ex_target : (ex_pc + 32'd4);
                end
            end
            FLUSH: begin
                if (r_flushCnt == '0) begin
                    w_nextState = IDLE;
                end else begin
                    w_nextFlushCnt = r_flushCnt - 1'b1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_flushCnt     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            r_state        <= w_nextState;
            r_flushCnt     <= w_nextFlushCnt;
            redirect_valid <= w_nextRedirValid;
            redirect_pc    <= w_nextRedirPc;
        end
    end

    // Saturating 2-bit counters, trained only on resolves accepted in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= CNT_INIT;
            end
        end else if (w_res) begin
            if (branch_sel) begin
                if (r_table[w_exIdx] != 2'b11) begin
                    r_table[w_exIdx] <= r_table[w_exIdx] + 2'b01;
                end
            end else begin
                if (r_table[w_exIdx] != 2'b00) begin
                    r_table[w_exIdx] <= r_table[w_exIdx] - 2'b01;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_count     <= 16'd0;
            mispredict_count <= 16'd0;
        end else begin
            if (w_res && (branch_count != 16'hFFFF)) begin
                branch_count <= branch_count + 16'd1;
            end
            if (w_mis && (mispredict_count != 16'hFFFF)) begin
                mispredict_count <= mispredict_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: expected redirects are queued by the
// stimulus and consumed by an independent monitor whenever redirect_valid fires.
module tb_branch_predict_ctrl;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_pred_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        branch_sel;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] expQ [$];

    branch_predict_ctrl #(
        .IDX_BITS    (6),
        .FLUSH_CYCLES(2),
        .CNT_INIT    (2'b01)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .ex_valid        (ex_valid),
        .ex_is_branch    (ex_is_branch),
        .ex_pred_taken   (ex_pred_taken),
        .ex_pc           (ex_pc),
        .ex_target       (ex_target),
        .branch_sel      (branch_sel),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .flush           (flush),
        .branch_count    (branch_count),
        .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One resolving branch in EX for a single cycle; a hand-computed redirect is queued.
    task automatic applyStimulus(input logic pred, input logic [31:0] pc, input logic [31:0] tgt,
                                 input logic sel, input logic expRedir, input logic [31:0] expPc);
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_pred_taken = pred;
        ex_pc         = pc;
        ex_target     = tgt;
        branch_sel    = sel;
        if (expRedir) expQ.push_back(expPc);
        tick();
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
    endtask

    task automatic checkPred(input string name, input logic [31:0] pc, input logic expected);
        if_valid = 1'b1;
        if_pc    = pc;
        #1;
        checkOutput(name, {31'd0, pred_taken}, {31'd0, expected});
    endtask

    // Scoreboard monitor: every redirect the DUT presents must match the queue head.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (redirect_valid === 1'b1) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_redirect: got pc %h expected no redirect", redirect_pc);
                end else begin
                    exp = expQ.pop_front();
                    if (redirect_pc !== exp) begin
                        errors++;
                        $display("[TB] FAIL redirect_pc: got %h expected %h", redirect_pc, exp);
                    end
                end
                checks++;
                if (flush !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL flush_with_redirect: got %b expected 1", flush);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_pc = '0;
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pred_taken = 1'b0;
        ex_pc = '0; ex_target = '0; branch_sel = 1'b0;

        // Reset held for two edges
        tick();
        tick();
        rst_n = 1'b1;
        checkOutput("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        checkOutput("rst_redirect_pc", redirect_pc, 32'd0);
        checkOutput("rst_flush", {31'd0, flush}, 32'd0);
        checkOutput("rst_branch_count", {16'd0, branch_count}, 32'd0);
        checkOutput("rst_mis_count", {16'd0, mispredict_count}, 32'd0);
        checkPred("rst_pred_100", 32'h100, 1'b0);
        checkPred("rst_pred_40", 32'h40, 1'b0);

        // Mispredicted taken branch
        applyStimulus(1'b0, 32'h100, 32'h80, 1'b1, 1'b1, 32'h80);
        checkOutput("mis_flush_c1", {31'd0, flush}, 32'd1);
        checkOutput("mis_count_1", {16'd0, mispredict_count}, 32'd1);
        checkOutput("br_count_1", {16'd0, branch_count}, 32'd1);
        tick();
        checkOutput("mis_flush_c2", {31'd0, flush}, 32'd1);
        checkOutput("mis_redir_drop", {31'd0, redirect_valid}, 32'd0);
        tick();
        checkOutput("mis_flush_end", {31'd0, flush}, 32'd0);
        checkPred("pred_100_taken", 32'h100, 1'b1);

        // Correct prediction: no redirect, no flush
        applyStimulus(1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 32'h0);
        checkOutput("ok_flush", {31'd0, flush}, 32'd0);
        checkOutput("br_count_2", {16'd0, branch_count}, 32'd2);
        checkOutput("mis_count_hold", {16'd0, mispredict_count}, 32'd1);

        // Non-branch in EX is ignored
        ex_valid = 1'b1; ex_is_branch = 1'b0; ex_pc = 32'h40;
        ex_pred_taken = 1'b0; branch_sel = 1'b1;
        tick();
        ex_valid = 1'b0;
        checkOutput("nonbr_count", {16'd0, branch_count}, 32'd2);
        checkOutput("nonbr_flush", {31'd0, flush}, 32'd0);

        // Not-taken fall-through wraps past the top of the address space
        applyStimulus(1'b1, 32'hFFFF_FFFC, 32'h1234, 1'b0, 1'b1, 32'h0000_0000);
        checkOutput("wrap_count", {16'd0, mispredict_count}, 32'd2);
        tick();
        tick();

        // Saturate the 0x40 counter at 3
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0);
        end
        checkOutput("sat_br_count", {16'd0, branch_count}, 32'd7);

        // Read-before-write on a same-index not-taken resolve
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pred_taken = 1'b0;
        ex_pc = 32'h40; branch_sel = 1'b0;
        checkPred("rbw_same_cycle", 32'h40, 1'b1);
        tick();
        ex_valid = 1'b0; ex_is_branch = 1'b0;
        checkPred("rbw_next_cycle", 32'h40, 1'b1);
        checkOutput("rbw_br_count", {16'd0, branch_count}, 32'd8);

        // Resolves offered during FLUSH are squashed
        applyStimulus(1'b1, 32'h80, 32'h999, 1'b0, 1'b1, 32'h84);
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pred_taken = 1'b1;
        ex_pc = 32'h40; ex_target = 32'h300; branch_sel = 1'b0;
        tick();
        checkOutput("sq_flush_c2", {31'd0, flush}, 32'd1);
        tick();
        ex_valid = 1'b0; ex_is_branch = 1'b0;
        checkOutput("sq_flush_end", {31'd0, flush}, 32'd0);
        checkOutput("sq_br_count", {16'd0, branch_count}, 32'd9);
        checkOutput("sq_mis_count", {16'd0, mispredict_count}, 32'd3);
        checkPred("sq_table_40", 32'h40, 1'b1);

        // Reset in the first FLUSH cycle wins
        applyStimulus(1'b0, 32'h80, 32'h500, 1'b1, 1'b1, 32'h500);
        checkOutput("mf_flush_before", {31'd0, flush}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("mf_flush", {31'd0, flush}, 32'd0);
        checkOutput("mf_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        checkOutput("mf_br_count", {16'd0, branch_count}, 32'd0);
        checkOutput("mf_mis_count", {16'd0, mispredict_count}, 32'd0);
        checkPred("mf_table_40", 32'h40, 1'b0);

        // IDLE again: a correct resolve counts without flushing
        applyStimulus(1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("mf_idle_count", {16'd0, branch_count}, 32'd1);
        checkOutput("mf_idle_flush", {31'd0, flush}, 32'd0);

        tick();
        tick();
        checkOutput("queue_drained", expQ.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
